pea_result_drain: RTL and testbench

Downstream consumer of the PEA output stage. Pops paired entries from the 32-bit result FIFO and 32-bit status FIFO, both written by the same `wr_out` strobe, and serializes each pair into a five-word 16-bit stream under a valid/ready handshake. The stream goes to the host-side link. Also keeps a sequence tag, a drained-pair counter and a sticky FIFO-desync flag for debug.

---
 rtl/pea_result_drain.sv | 156 +++++++++++++++
 tb/tb_pea_result_drain.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pea_result_drain.sv
// pea_result_drain
//   Drains paired entries from the PEA result and status output FIFOs and
//   serializes each pair into a five-word stream under valid/ready:
//     word 0: {8'hA5, seq}   word 1: status[31:16]   word 2: status[15:0]
//     word 3: result[31:16]  word 4: result[15:0]
//   Keeps an 8-bit sequence tag, a 16-bit drained-pair counter and a sticky
//   flag recording any population disagreement seen between the two FIFOs.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for both FIFOs non-empty; desync check runs here
//   POP     | rd_en to both FIFOs for this single cycle
//   CAPTURE | FIFO read data valid; latch result/status, reset word index
//   SEND    | present words 0..4 under valid/ready
//
// Ports
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   result_pop_i    result FIFO population
//   status_pop_i    status FIFO population
//   result_data_i   result FIFO read data (valid the cycle after rd_en)
//   status_data_i   status FIFO read data (valid the cycle after rd_en)
//   rd_en_result_o  result FIFO read strobe
//   rd_en_status_o  status FIFO read strobe
//   out_data_o      serialized word
//   out_valid_o     out_data_o is valid
//   out_ready_i     sink accepts the word
//   pair_count_o    pairs fully sent since reset (wraps)
//   busy_o          high whenever the FSM is not in IDLE
//   desync_err_o    sticky FIFO population mismatch flag

module pea_result_drain #(
  parameter int BUFFER_SIZE_OUT = 32,
  parameter int WIDTH           = 16,
  localparam int POP_W          = $clog2(BUFFER_SIZE_OUT)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [POP_W-1:0] result_pop_i,
  input  logic [POP_W-1:0] status_pop_i,
  input  logic [31:0]      result_data_i,
  input  logic [31:0]      status_data_i,
  output logic             rd_en_result_o,
  output logic             rd_en_status_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [15:0]      pair_count_o,
  output logic             busy_o,
  output logic             desync_err_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_POP     = 2'd1,
    S_CAPTURE = 2'd2,
    S_SEND    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] res_q, res_d;
  logic [31:0] sta_q, sta_d;
  logic [7:0]  seq_q, seq_d;
  logic [15:0] cnt_q, cnt_d;
  logic        desync_q, desync_d;
  logic        rd_en_q, rd_en_d;

  logic both_nz;
  assign both_nz = (|result_pop_i) && (|status_pop_i);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    res_d    = res_q;
    sta_d    = sta_q;
    seq_d    = seq_q;
    cnt_d    = cnt_q;
    desync_d = desync_q;
    case (state_q)
      S_IDLE: begin
        if (result_pop_i != status_pop_i) desync_d = 1'b1;
        if (both_nz) state_d = S_POP;
      end
      S_POP: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        res_d   = result_data_i;
        sta_d   = status_data_i;
        idx_d   = 3'd0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (out_ready_i) begin
          if (idx_q == 3'd4) begin
            seq_d   = seq_q + 8'd1;
            cnt_d   = cnt_q + 16'd1;
            // Skip IDLE when another pair is already waiting.
            state_d = both_nz ? S_POP : S_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered strobe: high exactly while the FSM sits in POP.
    rd_en_d = (state_d == S_POP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      idx_q    <= 3'd0;
      res_q    <= 32'd0;
      sta_q    <= 32'd0;
      seq_q    <= 8'd0;
      cnt_q    <= 16'd0;
      desync_q <= 1'b0;
      rd_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      res_q    <= res_d;
      sta_q    <= sta_d;
      seq_q    <= seq_d;
      cnt_q    <= cnt_d;
      desync_q <= desync_d;
      rd_en_q  <= rd_en_d;
    end
  end

  // Word mux depends only on registered state, so data is stable while stalled.
  always_comb begin
    out_data_o = '0;
    if (state_q == S_SEND) begin
      case (idx_q)
        3'd0:    out_data_o = {8'hA5, seq_q};
        3'd1:    out_data_o = sta_q[31:16];
        3'd2:    out_data_o = sta_q[15:0];
        3'd3:    out_data_o = res_q[31:16];
        3'd4:    out_data_o = res_q[15:0];
        default: out_data_o = '0;
      endcase
    end
  end

  assign out_valid_o    = (state_q == S_SEND);
  assign rd_en_result_o = rd_en_q;
  assign rd_en_status_o = rd_en_q;
  assign pair_count_o   = cnt_q;
  assign busy_o         = (state_q != S_IDLE);
  assign desync_err_o   = desync_q;

endmodule

// File: tb/tb_pea_result_drain.sv
module tb_pea_result_drain;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [4:0]  result_pop_i = 5'd0;
  logic [4:0]  status_pop_i = 5'd0;
  logic [31:0] result_data_i = 32'd0;
  logic [31:0] status_data_i = 32'd0;
  logic        rd_en_result_o;
  logic        rd_en_status_o;
  logic [15:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [15:0] pair_count_o;
  logic        busy_o;
  logic        desync_err_o;

  pea_result_drain #(.BUFFER_SIZE_OUT(32), .WIDTH(16)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .result_pop_i   (result_pop_i),
    .status_pop_i   (status_pop_i),
    .result_data_i  (result_data_i),
    .status_data_i  (status_data_i),
    .rd_en_result_o (rd_en_result_o),
    .rd_en_status_o (rd_en_status_o),
    .out_data_o     (out_data_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .pair_count_o   (pair_count_o),
    .busy_o         (busy_o),
    .desync_err_o   (desync_err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_res_cnt = 0;
  int rd_sta_cnt = 0;
  int rd_empty = 0;

  // FIFO models: registered read data, population updated on the same edge.
  logic [31:0] res_fifo[$];
  logic [31:0] sta_fifo[$];
  logic        wr_r = 1'b0, wr_s = 1'b0;
  logic [31:0] wr_rdata = 32'd0, wr_sdata = 32'd0;
  logic [31:0] tmp_r, tmp_s;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (rd_en_result_o) begin
      rd_res_cnt <= rd_res_cnt + 1;
      if (res_fifo.size() == 0) rd_empty <= rd_empty + 1;
      else begin
        tmp_r = res_fifo.pop_front();
        result_data_i <= tmp_r;
      end
    end
    if (rd_en_status_o) begin
      rd_sta_cnt <= rd_sta_cnt + 1;
      if (sta_fifo.size() == 0) rd_empty <= rd_empty + 1;
      else begin
        tmp_s = sta_fifo.pop_front();
        status_data_i <= tmp_s;
      end
    end
    if (wr_r) res_fifo.push_back(wr_rdata);
    if (wr_s) sta_fifo.push_back(wr_sdata);
    result_pop_i <= 5'(res_fifo.size());
    status_pop_i <= 5'(sta_fifo.size());
  end

  task automatic push(input logic do_r, input logic do_s,
                      input logic [31:0] r, input logic [31:0] s);
    @(negedge clk_i);
    wr_r = do_r; wr_s = do_s; wr_rdata = r; wr_sdata = s;
    @(posedge clk_i);
    #1;
    wr_r = 1'b0; wr_s = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Collects one five-word pair. bp=1 applies ready pattern 1,0,0,1,0,0...
  // per valid cycle and checks that stalled words are held.
  task automatic recv(input int bp, output logic [79:0] words,
                      output int t_first, output int t_last);
    int n = 0;
    int ph = 0;
    int guard = 0;
    logic pv = 1'b0, pr = 1'b0;
    logic [15:0] pd = 16'd0;
    words = '0; t_first = -1; t_last = -1;
    while (n < 5 && guard < 200) begin
      @(negedge clk_i);
      out_ready_i = (bp == 0) ? 1'b1 : (ph % 3 == 0);
      if (pv && !pr) begin
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== pd) begin
          failures++;
          $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h",
                   out_valid_o, out_data_o, pd);
        end
      end
      if (out_valid_o === 1'b1) begin
        if (t_first < 0) t_first = cyc;
        if (out_ready_i) begin
          words = {words[63:0], out_data_o};
          n++;
          t_last = cyc;
        end
        ph++;
      end
      pv = out_valid_o; pr = out_ready_i; pd = out_data_o;
      guard++;
    end
    if (n < 5) begin
      checks++; failures++;
      $display("FAIL recv_timeout: got %0d words, required 5", n);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({out_valid_o, out_data_o, rd_en_result_o, rd_en_status_o, busy_o, desync_err_o} !== 21'd0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b data=%h rd=%b%b busy=%b desync=%b, required all 0",
               out_valid_o, out_data_o, rd_en_result_o, rd_en_status_o, busy_o, desync_err_o);
    end
    checks++;
    if (pair_count_o !== 16'd0) begin
      failures++; $display("FAIL reset_pair_count: got %0d, required 0", pair_count_o);
    end
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || rd_en_result_o !== 1'b0) begin
      failures++; $display("FAIL idle_empty: busy=%b rd=%b, required 0 0", busy_o, rd_en_result_o);
    end
  endtask

  task automatic test_single_pair();
    logic [79:0] w; int tf, tl, c0, r0;
    r0 = rd_res_cnt;
    out_ready_i = 1'b1;
    push(1'b1, 1'b1, 32'h0000002A, 32'h00000001);
    c0 = cyc;
    recv(0, w, tf, tl);
    checks++;
    if (w !== {16'hA500, 16'h0000, 16'h0001, 16'h0000, 16'h002A}) begin
      failures++; $display("FAIL single_words: got %h, required a500000000010000002a", w);
    end
    checks++;
    if (tf - c0 != 3) begin
      failures++; $display("FAIL single_latency: got %0d cycles, required 3", tf - c0);
    end
    checks++;
    if (tl - tf != 4) begin
      failures++; $display("FAIL single_consecutive: span %0d, required 4", tl - tf);
    end
    @(negedge clk_i);
    checks++;
    if (pair_count_o !== 16'd1) begin
      failures++; $display("FAIL single_pair_count: got %0d, required 1", pair_count_o);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++; $display("FAIL single_busy: got %b, required 0", busy_o);
    end
    checks++;
    if (rd_res_cnt - r0 != 1) begin
      failures++; $display("FAIL single_pop_cycles: got %0d, required 1", rd_res_cnt - r0);
    end
  endtask

  task automatic test_backpressure();
    logic [79:0] w; int tf, tl;
    push(1'b1, 1'b1, 32'h0000002A, 32'h00000001);
    recv(1, w, tf, tl);
    out_ready_i = 1'b1;
    checks++;
    if (w !== {16'hA501, 16'h0000, 16'h0001, 16'h0000, 16'h002A}) begin
      failures++; $display("FAIL bp_words: got %h, required a501000000010000002a", w);
    end
    checks++;
    if (tl - tf != 12) begin
      failures++; $display("FAIL bp_span: got %0d, required 12", tl - tf);
    end
    @(negedge clk_i);
    checks++;
    if (pair_count_o !== 16'd2) begin
      failures++; $display("FAIL bp_pair_count: got %0d, required 2", pair_count_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [79:0] w, exp_w; int tf, tl, prev_tf;
    do_reset();
    out_ready_i = 1'b1;
    prev_tf = 0;
    fork
      begin
        for (int i = 0; i < 258; i++) begin
          int g = 0;
          while (res_fifo.size() >= 4 && g < 1000) begin
            @(posedge clk_i); g++;
          end
          push(1'b1, 1'b1, 32'h10000000 + i, 32'hC0000000 + (i * 3));
        end
      end
      begin
        for (int i = 0; i < 258; i++) begin
          logic [31:0] er, es; logic [7:0] tag;
          er = 32'h10000000 + i; es = 32'hC0000000 + (i * 3); tag = 8'(i);
          exp_w = {8'hA5, tag, es, er};
          recv(0, w, tf, tl);
          checks++;
          if (w !== exp_w) begin
            failures++; $display("FAIL b2b_pair%0d: got %h, required %h", i, w, exp_w);
          end
          if (i == 1 || i == 2) begin
            checks++;
            if (tf - prev_tf != 7) begin
              failures++; $display("FAIL b2b_spacing%0d: got %0d, required 7", i, tf - prev_tf);
            end
          end
          prev_tf = tf;
        end
      end
    join
    @(negedge clk_i);
    checks++;
    if (pair_count_o !== 16'd258) begin
      failures++; $display("FAIL b2b_pair_count: got %0d, required 258", pair_count_o);
    end
  endtask

  task automatic test_one_sided();
    logic [79:0] w; int tf, tl, r0, s0;
    r0 = rd_res_cnt; s0 = rd_sta_cnt;
    push(1'b1, 1'b0, 32'hDEADBEEF, 32'h0);
    repeat (6) @(negedge clk_i);
    checks++;
    if (rd_res_cnt != r0 || rd_sta_cnt != s0) begin
      failures++; $display("FAIL one_sided_rd: reads %0d/%0d, required 0/0", rd_res_cnt - r0, rd_sta_cnt - s0);
    end
    checks++;
    if (desync_err_o !== 1'b1) begin
      failures++; $display("FAIL one_sided_desync: got %b, required 1", desync_err_o);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++; $display("FAIL one_sided_busy: got %b, required 0", busy_o);
    end
    push(1'b0, 1'b1, 32'h0, 32'h12345678);
    recv(0, w, tf, tl);
    checks++;
    if (w !== {16'hA502, 16'h1234, 16'h5678, 16'hDEAD, 16'hBEEF}) begin
      failures++; $display("FAIL one_sided_words: got %h, required a50212345678deadbeef", w);
    end
    @(negedge clk_i);
    checks++;
    if (desync_err_o !== 1'b1) begin
      failures++; $display("FAIL desync_sticky: got %b, required 1", desync_err_o);
    end
    checks++;
    if (rd_empty != 0 || rd_res_cnt - r0 != 1 || rd_sta_cnt - s0 != 1) begin
      failures++; $display("FAIL one_sided_reads: empty=%0d res=%0d sta=%0d, required 0 1 1",
                           rd_empty, rd_res_cnt - r0, rd_sta_cnt - s0);
    end
  endtask

  task automatic test_reset_mid_send();
    logic [79:0] w; int tf, tl, n, g;
    out_ready_i = 1'b1;
    push(1'b1, 1'b1, 32'hAAAA5555, 32'h0BAD0F00);
    n = 0; g = 0;
    while (g < 50) begin
      @(negedge clk_i);
      g++;
      if (out_valid_o === 1'b1) begin
        if (n == 2) break;
        n++;
      end
    end
    checks++;
    if (out_data_o !== 16'h0F00) begin
      failures++; $display("FAIL mid_word2: got %h, required 0f00", out_data_o);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({out_valid_o, out_data_o, rd_en_result_o, rd_en_status_o, busy_o, desync_err_o, pair_count_o} !== 37'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs: valid=%b data=%h rd=%b%b busy=%b desync=%b cnt=%0d, required all 0",
               out_valid_o, out_data_o, rd_en_result_o, rd_en_status_o, busy_o, desync_err_o, pair_count_o);
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    push(1'b1, 1'b1, 32'h00000007, 32'h00000009);
    recv(0, w, tf, tl);
    checks++;
    if (w !== {16'hA500, 16'h0000, 16'h0009, 16'h0000, 16'h0007}) begin
      failures++; $display("FAIL post_reset_words: got %h, required a500000000090000 0007", w);
    end
    @(negedge clk_i);
    checks++;
    if (pair_count_o !== 16'd1) begin
      failures++; $display("FAIL post_reset_count: got %0d, required 1", pair_count_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_backpressure();
    test_back_to_back();
    test_one_sided();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
